// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// SERIAL_ADD_SUB_EN adds the per-operation subtract select.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output in_valid, a, b, out_ready,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/half_adder.sv
// Combinational half adder, the building block of the serial adder cell.
module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

// File: rtl/serial_add_bit.sv
// One-bit full adder from two half adders with the carries ORed together.
module serial_add_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0_s;
    logic c0_s;
    logic c1_s;

    half_adder u_ha0 (.x_i(a_i),  .y_i(b_i), .s_o(s0_s), .c_o(c0_s));
    half_adder u_ha1 (.x_i(s0_s), .y_i(c_i), .s_o(s_o),  .c_o(c1_s));

    assign c_o = c0_s | c1_s;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts a/b, adds LSB-first over WIDTH cycles, then holds sum/carry.
// Optional feature macro SERIAL_ADD_SUB_EN enables a - b via inverted b and carry-in of one.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_ctrl_if.slave      bus,
    output logic                  busy
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             op_sub_s;
    logic             cell_s;
    logic             cell_c;

`ifdef SERIAL_ADD_SUB_EN
    assign op_sub_s = bus.sub;
`else
    assign op_sub_s = 1'b0;
`endif

    serial_add_bit u_bit (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (cy_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    // Next-state, datapath shifting and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cy_d     = cy_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction stores ~b so the cell stays a plain adder.
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b ^ {WIDTH{op_sub_s}};
                    cy_d    = op_sub_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = {cell_s, sum_sr_q[WIDTH-1:1]};
                cy_d     = cell_c;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {cell_s, sum_sr_q[WIDTH-1:1]};
                    carry_d = cell_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_RUN);
        out_valid_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            a_sr_q      <= {WIDTH{1'b0}};
            b_sr_q      <= {WIDTH{1'b0}};
            sum_sr_q    <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cy_q        <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            sum_q       <= sum_d;
            cy_q        <= cy_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign busy          = busy_q;

endmodule
